// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture controller.
package ov7670_pkg;

    // Capture controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_SYNC    = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_t;

    // The camera sends the high byte of each RGB565 pixel first.
    localparam bit HIGH_BYTE_FIRST = 1'b1;

    // Places the two received bytes into a 16-bit pixel in transmission order.
    function automatic logic [15:0] pack_pixel(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte);
        logic [15:0] pix;
        if (HIGH_BYTE_FIRST) begin
            pix = {first_byte, second_byte};
        end else begin
            pix = {second_byte, first_byte};
        end
        return pix;
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Assembles two consecutive href-qualified camera bytes into one pixel write.
module ov7670_byte_pair
    import ov7670_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        href,
    input  logic        block,
    input  logic [7:0]  d,
    output logic        pair_sample,
    output logic        wr_en,
    output logic [15:0] wr_data
);

    logic        phase_r;
    logic [7:0]  high_r;
    logic        wr_en_r;
    logic [15:0] wr_data_r;

    // Second byte of a pixel is being sampled this cycle.
    assign pair_sample = en & href & phase_r;

    // Byte phase tracking, first-byte latch and registered write strobe.
    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_r   <= 1'b0;
            high_r    <= 8'h00;
            wr_en_r   <= 1'b0;
            wr_data_r <= 16'h0000;
        end else if (clr) begin
            phase_r   <= 1'b0;
            high_r    <= 8'h00;
            wr_en_r   <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            if (en && href) begin
                if (!phase_r) begin
                    high_r  <= d;
                    phase_r <= 1'b1;
                end else begin
                    phase_r <= 1'b0;
                    // A blocked pixel is dropped; the controller flags the overflow.
                    if (!block) begin
                        wr_en_r   <= 1'b1;
                        wr_data_r <= pack_pixel(high_r, d);
                    end
                end
            end else begin
                // href low drops any dangling odd byte.
                phase_r <= 1'b0;
            end
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_data = wr_data_r;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame capture controller: arms on start, waits for a vsync pulse,
// then writes assembled pixels to a frame buffer while checking geometry.
module ov7670_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480,
    parameter int BYTES_PER_PIXEL   = 2
) (
    input  logic                                                   pclk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic                                                   continuous,
    input  logic                                                   vsync,
    input  logic                                                   href,
    input  logic [7:0]                                             D,
    output logic                                                   wr_en,
    output logic [$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT)-1:0]  wr_addr,
    output logic [15:0]                                            wr_data,
    output logic                                                   busy,
    output logic                                                   frame_done,
    output logic                                                   err_line,
    output logic                                                   err_frame
);

    localparam int PIXELS     = RESOLUTION_WIDTH * RESOLUTION_HEIGHT;
    localparam int ADDR_W     = $clog2(PIXELS);
    localparam int LINE_BYTES = RESOLUTION_WIDTH * BYTES_PER_PIXEL;
    localparam int BYTE_W     = $clog2(LINE_BYTES + 1) + 1;
    localparam int LINE_W     = $clog2(RESOLUTION_HEIGHT + 1) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [BYTE_W-1:0] BYTE_MAX  = {BYTE_W{1'b1}};
    localparam logic [LINE_W-1:0] LINE_MAX  = {LINE_W{1'b1}};

    cap_state_t        state_r;
    cap_state_t        state_next_s;
    logic              cont_mode_r;
    logic              vsync_q_r;
    logic              href_q_r;
    logic [ADDR_W-1:0] addr_r;
    logic              addr_full_r;
    logic [LINE_W-1:0] line_cnt_r;
    logic [LINE_W-1:0] line_cnt_final_s;
    logic [BYTE_W-1:0] byte_cnt_r;
    logic              frame_done_r;
    logic              err_line_r;
    logic              err_frame_r;
    logic              busy_r;

    logic              capture_s;
    logic              vsync_rise_s;
    logic              href_fall_s;
    logic              enter_capture_s;
    logic              pair_sample_s;
    logic              wr_en_s;

    assign capture_s       = (state_r == ST_CAPTURE);
    assign vsync_rise_s    = vsync & ~vsync_q_r;
    assign href_fall_s     = capture_s & href_q_r & ~href;
    assign enter_capture_s = (state_r == ST_SYNC) & ~vsync;

    ov7670_byte_pair u_byte_pair (
        .pclk        (pclk),
        .rst         (rst),
        .clr         (enter_capture_s),
        .en          (capture_s),
        .href        (href),
        .block       (addr_full_r),
        .d           (D),
        .pair_sample (pair_sample_s),
        .wr_en       (wr_en_s),
        .wr_data     (wr_data)
    );

    // Line count including a line that ends this very cycle, so a coincident
    // href fall is counted before the frame-length check.
    always_comb begin
        line_cnt_final_s = line_cnt_r;
        if (href_fall_s && (line_cnt_r != LINE_MAX)) begin
            line_cnt_final_s = line_cnt_r + LINE_W'(1);
        end else begin
            line_cnt_final_s = line_cnt_r;
        end
    end

    // Next-state decode for the capture sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_ARM;
                else       state_next_s = ST_IDLE;
            end
            ST_ARM: begin
                if (vsync) state_next_s = ST_SYNC;
                else       state_next_s = ST_ARM;
            end
            ST_SYNC: begin
                if (!vsync) state_next_s = ST_CAPTURE;
                else        state_next_s = ST_SYNC;
            end
            ST_CAPTURE: begin
                if (vsync_rise_s) state_next_s = cont_mode_r ? ST_SYNC : ST_IDLE;
                else              state_next_s = ST_CAPTURE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, mode latch, edge-detect history and status outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cont_mode_r  <= 1'b0;
            vsync_q_r    <= 1'b0;
            href_q_r     <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
            vsync_q_r    <= vsync;
            href_q_r     <= capture_s ? href : 1'b0;
            frame_done_r <= capture_s & vsync_rise_s;
            if ((state_r == ST_IDLE) && start) begin
                cont_mode_r <= continuous;
            end
        end
    end

    // Pixel address, line/byte counters and sticky geometry error flags.
    always_ff @(posedge pclk) begin
        if (rst) begin
            addr_r      <= '0;
            addr_full_r <= 1'b0;
            line_cnt_r  <= '0;
            byte_cnt_r  <= '0;
            err_line_r  <= 1'b0;
            err_frame_r <= 1'b0;
        end else if (enter_capture_s) begin
            addr_r      <= '0;
            addr_full_r <= 1'b0;
            line_cnt_r  <= '0;
            byte_cnt_r  <= '0;
            err_line_r  <= 1'b0;
            err_frame_r <= 1'b0;
        end else begin
            // Advance after each write; the last address is held, never wrapped.
            if (wr_en_s) begin
                if (addr_r == LAST_ADDR) addr_full_r <= 1'b1;
                else                     addr_r      <= addr_r + ADDR_W'(1);
            end
            if (capture_s) begin
                if (href_fall_s) begin
                    byte_cnt_r <= '0;
                    line_cnt_r <= line_cnt_final_s;
                    if (byte_cnt_r != BYTE_W'(LINE_BYTES)) err_line_r <= 1'b1;
                end else if (href && (byte_cnt_r != BYTE_MAX)) begin
                    byte_cnt_r <= byte_cnt_r + BYTE_W'(1);
                end
                if (pair_sample_s && addr_full_r) begin
                    err_frame_r <= 1'b1;
                end
                if (vsync_rise_s && (line_cnt_final_s != LINE_W'(RESOLUTION_HEIGHT))) begin
                    err_frame_r <= 1'b1;
                end
            end
        end
    end

    assign wr_en      = wr_en_s;
    assign wr_addr    = addr_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign err_line   = err_line_r;
    assign err_frame  = err_frame_r;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Directed bench for ov7670_capture_ctrl with a 4x3 frame.
module tb_ov7670_capture_ctrl;

    localparam int W = 4;
    localparam int H = 3;

    logic        pclk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        vsync;
    logic        href;
    logic [7:0]  D;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic        err_line;
    logic        err_frame;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    int          fd_cnt = 0;
    int          busy_low_cnt = 0;
    bit          watch_busy = 1'b0;

    ov7670_capture_ctrl #(
        .RESOLUTION_WIDTH  (W),
        .RESOLUTION_HEIGHT (H),
        .BYTES_PER_PIXEL   (2)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .vsync      (vsync),
        .href       (href),
        .D          (D),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .err_line   (err_line),
        .err_frame  (err_frame)
    );

    always #5 pclk = ~pclk;

    // Write / frame_done / busy monitor, sampled on the falling edge.
    always @(negedge pclk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
        if (frame_done) fd_cnt++;
        if (watch_busy && !busy) busy_low_cnt++;
    end

    function automatic logic [7:0] bv(input int l, input int k);
        int v;
        v = l * 16 + k + 33;
        return v[7:0];
    endfunction

    function automatic logic [15:0] px(input int l, input int j);
        return {bv(l, 2 * j), bv(l, 2 * j + 1)};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick(3);
        vsync = 1'b0;
        tick(2);
    endtask

    task automatic send_line(input int l, input int nbytes, input int gap);
        href = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            D = bv(l, k);
            tick();
        end
        href = 1'b0;
        D = 8'h00;
        tick(gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; href = 1'b1; D = 8'hFF; start = 1'b1;
        tick(3);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL reset_err_line: got %b expected 0", err_line); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL reset_err_frame: got %b expected 0", err_frame); end
        rst = 1'b0; href = 1'b0; D = 8'h00; start = 1'b0;
        tick(2);
    endtask

    task automatic test_clean_frame();
        int bw, bf;
        bw = wq_addr.size(); bf = fd_cnt;
        do_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy_arm: got %b expected 1", busy); end
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(l, 8, 2);
        vsync_pulse();
        n_checks++; if (wq_addr.size() - bw != 12) begin n_fail++; $display("FAIL clean_write_count: got %0d expected 12", wq_addr.size() - bw); end
        if (wq_addr.size() >= bw + 12) begin
            for (int p = 0; p < 12; p++) begin
                n_checks++; if (wq_addr[bw + p] !== 4'(p)) begin n_fail++; $display("FAIL clean_addr[%0d]: got %0d expected %0d", p, wq_addr[bw + p], p); end
                n_checks++; if (wq_data[bw + p] !== px(p / W, p % W)) begin n_fail++; $display("FAIL clean_data[%0d]: got %h expected %h", p, wq_data[bw + p], px(p / W, p % W)); end
            end
        end
        n_checks++; if (fd_cnt - bf != 1) begin n_fail++; $display("FAIL clean_frame_done: got %0d pulses expected 1", fd_cnt - bf); end
        n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL clean_err_line: got %b expected 0", err_line); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL clean_err_frame: got %b expected 0", err_frame); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_byte_assembly();
        logic [7:0] b [8];
        int bf;
        b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'hAB; b[3] = 8'hCD;
        b[4] = 8'h56; b[5] = 8'h78; b[6] = 8'h9A; b[7] = 8'hBC;
        bf = fd_cnt;
        do_start();
        vsync_pulse();
        href = 1'b1;
        for (int k = 0; k < 8; k++) begin
            D = b[k];
            tick();
            if (k == 0 || k == 2) begin
                n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL asm_no_write_k%0d: wr_en got %b expected 0", k, wr_en); end
            end
            if (k == 1) begin
                n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL asm_wr_en_0: got %b expected 1", wr_en); end
                n_checks++; if (wr_data !== 16'h1234) begin n_fail++; $display("FAIL asm_data_0: got %h expected 1234", wr_data); end
                n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL asm_addr_0: got %0d expected 0", wr_addr); end
            end
            if (k == 3) begin
                n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL asm_wr_en_1: got %b expected 1", wr_en); end
                n_checks++; if (wr_data !== 16'hABCD) begin n_fail++; $display("FAIL asm_data_1: got %h expected abcd", wr_data); end
                n_checks++; if (wr_addr !== 4'd1) begin n_fail++; $display("FAIL asm_addr_1: got %0d expected 1", wr_addr); end
            end
        end
        href = 1'b0; D = 8'h00;
        tick(2);
        send_line(1, 8, 2);
        send_line(2, 8, 2);
        vsync_pulse();
        n_checks++; if (fd_cnt - bf != 1) begin n_fail++; $display("FAIL asm_frame_done: got %0d expected 1", fd_cnt - bf); end
        n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL asm_err_line: got %b expected 0", err_line); end
    endtask

    task automatic test_short_line();
        int bw, bf;
        bw = wq_addr.size(); bf = fd_cnt;
        do_start();
        vsync_pulse();
        send_line(0, 8, 2);
        send_line(1, 7, 2);
        send_line(2, 8, 2);
        vsync_pulse();
        n_checks++; if (wq_addr.size() - bw != 11) begin n_fail++; $display("FAIL short_write_count: got %0d expected 11", wq_addr.size() - bw); end
        if (wq_addr.size() >= bw + 11) begin
            n_checks++; if (wq_addr[bw + 10] !== 4'd10) begin n_fail++; $display("FAIL short_last_addr: got %0d expected 10", wq_addr[bw + 10]); end
            n_checks++; if (wq_data[bw + 6] !== px(1, 2)) begin n_fail++; $display("FAIL short_data_6: got %h expected %h", wq_data[bw + 6], px(1, 2)); end
            n_checks++; if (wq_data[bw + 7] !== px(2, 0)) begin n_fail++; $display("FAIL short_odd_dropped: got %h expected %h", wq_data[bw + 7], px(2, 0)); end
        end
        n_checks++; if (err_line !== 1'b1) begin n_fail++; $display("FAIL short_err_line: got %b expected 1", err_line); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL short_err_frame: got %b expected 0", err_frame); end
        n_checks++; if (fd_cnt - bf != 1) begin n_fail++; $display("FAIL short_frame_done: got %0d expected 1", fd_cnt - bf); end
    endtask

    task automatic test_line_count(input int nlines, input int exp_writes);
        int bw, bf;
        bw = wq_addr.size(); bf = fd_cnt;
        do_start();
        vsync_pulse();
        for (int l = 0; l < nlines; l++) send_line(l, 8, 2);
        vsync_pulse();
        n_checks++; if (wq_addr.size() - bw != exp_writes) begin n_fail++; $display("FAIL lines%0d_write_count: got %0d expected %0d", nlines, wq_addr.size() - bw, exp_writes); end
        if (nlines > H) begin
            n_checks++; if (wr_addr !== 4'd11) begin n_fail++; $display("FAIL lines%0d_addr_saturate: got %0d expected 11", nlines, wr_addr); end
            if (wq_addr.size() >= bw + 12) begin
                n_checks++; if (wq_addr[bw + 11] !== 4'd11) begin n_fail++; $display("FAIL lines%0d_last_write: got %0d expected 11", nlines, wq_addr[bw + 11]); end
            end
        end
        n_checks++; if (err_frame !== 1'b1) begin n_fail++; $display("FAIL lines%0d_err_frame: got %b expected 1", nlines, err_frame); end
        n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL lines%0d_err_line: got %b expected 0", nlines, err_line); end
        n_checks++; if (fd_cnt - bf != 1) begin n_fail++; $display("FAIL lines%0d_frame_done: got %0d expected 1", nlines, fd_cnt - bf); end
    endtask

    task automatic test_same_cycle_edges();
        int bw, bf;
        bw = wq_addr.size(); bf = fd_cnt;
        do_start();
        vsync_pulse();
        send_line(0, 8, 2);
        send_line(1, 8, 2);
        send_line(2, 8, 0);
        vsync_pulse();
        n_checks++; if (wq_addr.size() - bw != 12) begin n_fail++; $display("FAIL same_write_count: got %0d expected 12", wq_addr.size() - bw); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL same_err_frame: got %b expected 0", err_frame); end
        n_checks++; if (err_line !== 1'b0) begin n_fail++; $display("FAIL same_err_line: got %b expected 0", err_line); end
        n_checks++; if (fd_cnt - bf != 1) begin n_fail++; $display("FAIL same_frame_done: got %0d expected 1", fd_cnt - bf); end
    endtask

    task automatic test_continuous();
        int bw, bf, bb;
        bw = wq_addr.size(); bf = fd_cnt; bb = busy_low_cnt;
        continuous = 1'b1;
        do_start();
        watch_busy = 1'b1;
        vsync_pulse();
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < H; l++) send_line(l, 8, 2);
            vsync_pulse();
        end
        watch_busy = 1'b0;
        n_checks++; if (fd_cnt - bf != 3) begin n_fail++; $display("FAIL cont_frame_done: got %0d expected 3", fd_cnt - bf); end
        n_checks++; if (wq_addr.size() - bw != 36) begin n_fail++; $display("FAIL cont_write_count: got %0d expected 36", wq_addr.size() - bw); end
        if (wq_addr.size() >= bw + 36) begin
            for (int f = 0; f < 3; f++) begin
                n_checks++; if (wq_addr[bw + f * 12] !== 4'd0) begin n_fail++; $display("FAIL cont_restart_f%0d: got %0d expected 0", f, wq_addr[bw + f * 12]); end
                n_checks++; if (wq_addr[bw + f * 12 + 11] !== 4'd11) begin n_fail++; $display("FAIL cont_last_f%0d: got %0d expected 11", f, wq_addr[bw + f * 12 + 11]); end
            end
        end
        n_checks++; if (busy_low_cnt - bb != 0) begin n_fail++; $display("FAIL cont_busy_low: got %0d low cycles expected 0", busy_low_cnt - bb); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy_end: got %b expected 1", busy); end
        continuous = 1'b0;
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mid_start_reset();
        int bw;
        bw = wq_addr.size();
        href = 1'b1;
        for (int k = 0; k < 8; k++) begin
            D = bv(0, k);
            start = (k == 2);
            tick();
        end
        start = 1'b0; href = 1'b0; D = 8'h00;
        tick(2);
        send_line(1, 8, 2);
        send_line(2, 8, 2);
        n_checks++; if (wq_addr.size() - bw != 0) begin n_fail++; $display("FAIL mid_early_write: got %0d writes expected 0", wq_addr.size() - bw); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_armed: busy got %b expected 1", busy); end
        vsync_pulse();
        send_line(0, 8, 2);
        n_checks++; if (wq_addr.size() - bw != 4) begin n_fail++; $display("FAIL mid_first_line: got %0d writes expected 4", wq_addr.size() - bw); end
        if (wq_addr.size() >= bw + 1) begin
            n_checks++; if (wq_addr[bw] !== 4'd0) begin n_fail++; $display("FAIL mid_first_addr: got %0d expected 0", wq_addr[bw]); end
            n_checks++; if (wq_data[bw] !== px(0, 0)) begin n_fail++; $display("FAIL mid_first_data: got %h expected %h", wq_data[bw], px(0, 0)); end
        end
        href = 1'b1;
        for (int k = 0; k < 4; k++) begin
            D = bv(1, k);
            tick();
        end
        n_checks++; if (wr_addr !== 4'd5) begin n_fail++; $display("FAIL mid_pre_reset_addr: got %0d expected 5", wr_addr); end
        rst = 1'b1; D = bv(1, 4);
        tick();
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_cap_wr_en: got %b expected 0", wr_en); end
        n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL rst_cap_wr_addr: got %0d expected 0", wr_addr); end
        n_checks++; if (wr_data !== 16'h0000) begin n_fail++; $display("FAIL rst_cap_wr_data: got %h expected 0000", wr_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_cap_busy: got %b expected 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_cap_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        bw = wq_addr.size();
        for (int k = 5; k < 8; k++) begin
            D = bv(1, k);
            start = (k == 5);
            tick();
        end
        start = 1'b0; href = 1'b0; D = 8'h00;
        tick(2);
        send_line(2, 8, 2);
        n_checks++; if (wq_addr.size() - bw != 0) begin n_fail++; $display("FAIL rst_partial_write: got %0d writes expected 0", wq_addr.size() - bw); end
        vsync_pulse();
        send_line(2, 8, 2);
        n_checks++; if (wq_addr.size() - bw != 4) begin n_fail++; $display("FAIL rst_next_line: got %0d writes expected 4", wq_addr.size() - bw); end
        if (wq_addr.size() >= bw + 1) begin
            n_checks++; if (wq_addr[bw] !== 4'd0) begin n_fail++; $display("FAIL rst_next_addr: got %0d expected 0", wq_addr[bw]); end
            n_checks++; if (wq_data[bw] !== px(2, 0)) begin n_fail++; $display("FAIL rst_next_data: got %h expected %h", wq_data[bw], px(2, 0)); end
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
        vsync = 1'b0; href = 1'b0; D = 8'h00;
        test_reset();
        test_clean_frame();
        test_byte_assembly();
        test_short_line();
        test_line_count(H + 1, 12);
        test_line_count(H - 1, 8);
        test_same_cycle_edges();
        test_continuous();
        test_mid_start_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
